// File: rtl/max_pool_33_s2_pkg.sv
// Shared constants and helpers for the streaming 3x3 stride-2 float max-pool stage.
package max_pool_33_s2_pkg;

    localparam int unsigned DEF_WIDTH      = 35;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned FP_SIGN_BIT    = DEF_DATA_WIDTH - 1;
    localparam int unsigned FP_MAG_MSB     = DEF_DATA_WIDTH - 2;

    function automatic int unsigned fp_sign_bit(input int unsigned dw);
        return dw - 1;
    endfunction

    function automatic int unsigned fp_mag_msb(input int unsigned dw);
        return dw - 2;
    endfunction

    // Pooled plane side length for a valid-padding 3x3/2 window.
    function automatic int unsigned out_w(input int unsigned width);
        return (width - 3) / 2 + 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/max_pool_33_s2_fp_max2.sv
// Combinational two-input IEEE-754 max; on a tie (including +0/-0) operand a is returned.
module max_pool_33_s2_fp_max2
    import max_pool_33_s2_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] max_c_o
);

    localparam int unsigned SB = fp_sign_bit(DATA_WIDTH);
    localparam int unsigned MB = fp_mag_msb(DATA_WIDTH);

    logic [MB:0] mag_a_c;
    logic [MB:0] mag_b_c;

    always_comb begin
        mag_a_c = a_i[MB:0];
        mag_b_c = b_i[MB:0];
        max_c_o = a_i;
        if (a_i[SB] != b_i[SB]) begin
            // Differing signs: the non-negative operand wins unless both are zeros.
            if ((mag_a_c != '0) || (mag_b_c != '0)) begin
                max_c_o = a_i[SB] ? b_i : a_i;
            end
        end else if (!a_i[SB]) begin
            if (mag_b_c > mag_a_c) begin
                max_c_o = b_i;
            end
        end else begin
            if (mag_b_c < mag_a_c) begin
                max_c_o = b_i;
            end
        end
    end

endmodule

// File: rtl/max_pool_33_s2.sv
// Streaming 3x3, stride-2, valid-padding max-pool over raster-ordered float planes.
module max_pool_33_s2
    import max_pool_33_s2_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out
);

    localparam int unsigned CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0]         col_q, col_d;
    logic [CW-1:0]         row_q, row_d;
    logic [DATA_WIDTH-1:0] lb_r1_q [WIDTH];
    logic [DATA_WIDTH-1:0] lb_r2_q [WIDTH];

    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_emit_q, s1_emit_d;
    logic [DATA_WIDTH-1:0] s1_cm_q, s1_cm_d;
    logic [DATA_WIDTH-1:0] cm_d1_q, cm_d1_d;
    logic [DATA_WIDTH-1:0] cm_d2_q, cm_d2_d;
    logic [DATA_WIDTH-1:0] pxl_out_q, pxl_out_d;
    logic                  valid_out_q, valid_out_d;

    logic [DATA_WIDTH-1:0] rd_r1_c, rd_r2_c;
    logic [DATA_WIDTH-1:0] s1_pair_c, s1_cm_c;
    logic [DATA_WIDTH-1:0] s2_pair_c, s2_max_c;
    logic                  take_c, emit_c;

    assign rd_r1_c = lb_r1_q[col_q];
    assign rd_r2_c = lb_r2_q[col_q];
    assign take_c  = valid_in && !reset;
    // Current pixel is the bottom-right corner of a pooling window.
    assign emit_c  = (row_q >= CW'(2)) && !row_q[0] && (col_q >= CW'(2)) && !col_q[0];

    // Operand order keeps the newest (lowest / rightmost) value as the tie winner.
    max_pool_33_s2_fp_max2 #(.DATA_WIDTH(DATA_WIDTH)) u_s1_pair (
        .a_i(rd_r1_c), .b_i(rd_r2_c), .max_c_o(s1_pair_c));
    max_pool_33_s2_fp_max2 #(.DATA_WIDTH(DATA_WIDTH)) u_s1_cm (
        .a_i(pxl_in), .b_i(s1_pair_c), .max_c_o(s1_cm_c));
    max_pool_33_s2_fp_max2 #(.DATA_WIDTH(DATA_WIDTH)) u_s2_pair (
        .a_i(cm_d1_q), .b_i(cm_d2_q), .max_c_o(s2_pair_c));
    max_pool_33_s2_fp_max2 #(.DATA_WIDTH(DATA_WIDTH)) u_s2_max (
        .a_i(s1_cm_q), .b_i(s2_pair_c), .max_c_o(s2_max_c));

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        s1_valid_d  = valid_in;
        s1_emit_d   = valid_in && emit_c;
        s1_cm_d     = s1_cm_q;
        cm_d1_d     = cm_d1_q;
        cm_d2_d     = cm_d2_q;
        pxl_out_d   = pxl_out_q;
        valid_out_d = 1'b0;

        if (valid_in) begin
            s1_cm_d = s1_cm_c;
            if (col_q == LAST) begin
                col_d = '0;
                row_d = (row_q == LAST) ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        // Column-max history advances only on real stage-1 data, so bubbles are transparent.
        if (s1_valid_q) begin
            cm_d1_d = s1_cm_q;
            cm_d2_d = cm_d1_q;
            if (s1_emit_q) begin
                pxl_out_d   = s2_max_c;
                valid_out_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_emit_q   <= 1'b0;
            s1_cm_q     <= '0;
            cm_d1_q     <= '0;
            cm_d2_q     <= '0;
            pxl_out_q   <= '0;
            valid_out_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            s1_valid_q  <= s1_valid_d;
            s1_emit_q   <= s1_emit_d;
            s1_cm_q     <= s1_cm_d;
            cm_d1_q     <= cm_d1_d;
            cm_d2_q     <= cm_d2_d;
            pxl_out_q   <= pxl_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    // Line buffers are never cleared; rows 0-1 of a plane never emit, so stale data cannot leak.
    always_ff @(posedge clk) begin
        if (take_c) begin
            lb_r2_q[col_q] <= rd_r1_c;
            lb_r1_q[col_q] <= pxl_in;
        end
    end

    assign pxl_out   = pxl_out_q;
    assign valid_out = valid_out_q;

endmodule

// File: tb/tb_max_pool_33_s2.sv
// Self-checking bench: window-level float max model plus directed literal expectations.
module tb_max_pool_33_s2;

    localparam int unsigned DW = 32;

    typedef struct {
        logic [DW-1:0] v;
        int unsigned   due;
    } exp_t;

    logic          clk   = 1'b0;
    int unsigned   cyc   = 0;
    int            checks = 0;
    int            errors = 0;

    logic          rst_a = 1'b1, vin_a = 1'b0, vout_a;
    logic [DW-1:0] pin_a = '0, pout_a;
    logic          rst_b = 1'b1, vin_b = 1'b0, vout_b;
    logic [DW-1:0] pin_b = '0, pout_b;

    exp_t          qa[$];
    exp_t          qb[$];
    logic [DW-1:0] got_a[$];
    int unsigned   nb_out = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    max_pool_33_s2 #(.WIDTH(5), .DATA_WIDTH(DW)) dut_a (
        .clk(clk), .reset(rst_a), .valid_in(vin_a), .pxl_in(pin_a),
        .pxl_out(pout_a), .valid_out(vout_a));

    max_pool_33_s2 #(.WIDTH(35), .DATA_WIDTH(DW)) dut_b (
        .clk(clk), .reset(rst_b), .valid_in(vin_b), .pxl_in(pin_b),
        .pxl_out(pout_b), .valid_out(vout_b));

    // Total order on finite floats; -0 and +0 map to the same key.
    function automatic longint fkey(input logic [DW-1:0] x);
        longint m;
        m = longint'(x[DW-2:0]);
        return x[DW-1] ? -m : m;
    endfunction

    // Window max; rightmost column, then bottom row, wins ties.
    function automatic logic [DW-1:0] win_max(input logic [DW-1:0] img[], input int base,
                                              input int w, input int r, input int c);
        logic [DW-1:0] best;
        best = img[base + r*w + c];
        for (int cc = c; cc >= c - 2; cc--)
            for (int rr = r; rr >= r - 2; rr--)
                if (fkey(img[base + rr*w + cc]) > fkey(best)) best = img[base + rr*w + cc];
        return best;
    endfunction

    function automatic logic [DW-1:0] i2f(input int unsigned k);
        int p;
        p = 0;
        if (k == 0) return '0;
        for (int i = 0; i < 24; i++) if (k[i]) p = i;
        return {1'b0, 8'(127 + p), 23'(k << (23 - p))};
    endfunction

    function automatic logic [DW-1:0] rand_float();
        return {1'($urandom_range(1, 0)), 8'($urandom_range(150, 100)), 23'($urandom)};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic drive(input int which, input logic v, input logic [DW-1:0] p);
        if (which == 0) begin vin_a = v; pin_a = p; end
        else begin vin_b = v; pin_b = p; end
    endtask

    // Feeds npix pixels; each window's bottom-right pixel schedules an output 2 cycles later.
    task automatic feed(input int which, input logic [DW-1:0] img[], input int w,
                        input int npix, input int idle_pct);
        int r, c, base;
        exp_t e;
        for (int k = 0; k < npix; k++) begin
            while (idle_pct > 0 && int'($urandom_range(99, 0)) < idle_pct) begin
                drive(which, 1'b0, $urandom);
                @(negedge clk); #1;
            end
            base = (k / (w*w)) * w * w;
            r = (k % (w*w)) / w;
            c = k % w;
            drive(which, 1'b1, img[k]);
            if (r >= 2 && r % 2 == 0 && c >= 2 && c % 2 == 0) begin
                e = '{win_max(img, base, w, r, c), cyc + 2};
                if (which == 0) qa.push_back(e); else qb.push_back(e);
            end
            @(negedge clk); #1;
        end
        drive(which, 1'b0, '0);
    endtask

    task automatic drain_a(input string name);
        repeat (4) @(negedge clk);
        #1;
        chk({name, "_pending"}, 32'(qa.size()), 32'd0);
    endtask

    // Compare process: every valid_out must match the oldest expectation at its due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (vout_a) begin
            got_a.push_back(pout_a);
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected: got %h expected no output (cycle %0d)", pout_a, cyc);
            end else begin
                e = qa.pop_front();
                if (pout_a !== e.v || cyc != e.due) begin
                    errors++;
                    $display("FAIL a_out: got %h at cycle %0d expected %h at cycle %0d",
                             pout_a, cyc, e.v, e.due);
                end
            end
        end else if (qa.size() > 0 && qa[0].due <= cyc) begin
            checks++;
            errors++;
            $display("FAIL a_missing: got none expected %h at cycle %0d", qa[0].v, qa[0].due);
            void'(qa.pop_front());
        end
        if (vout_b) begin
            nb_out++;
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected: got %h expected no output (cycle %0d)", pout_b, cyc);
            end else begin
                e = qb.pop_front();
                if (pout_b !== e.v || cyc != e.due) begin
                    errors++;
                    $display("FAIL b_out: got %h at cycle %0d expected %h at cycle %0d",
                             pout_b, cyc, e.v, e.due);
                end
            end
        end else if (qb.size() > 0 && qb[0].due <= cyc) begin
            checks++;
            errors++;
            $display("FAIL b_missing: got none expected %h at cycle %0d", qb[0].v, qb[0].due);
            void'(qb.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] ramp[];
        logic [DW-1:0] neg[];
        logic [DW-1:0] zer[];
        logic [DW-1:0] rnd[];
        logic [DW-1:0] lit[4];

        lit = '{32'h41400000, 32'h41600000, 32'h41B00000, 32'h41C00000};
        ramp = new[25];
        for (int k = 0; k < 25; k++) ramp[k] = i2f(k);

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_vout_a", 32'(vout_a), 32'd0);
        chk("rst_pout_a", pout_a, 32'h0);
        chk("rst_vout_b", 32'(vout_b), 32'd0);
        chk("rst_pout_b", pout_b, 32'h0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk); #1;

        // Ramp plane 0..24
        got_a.delete();
        feed(0, ramp, 5, 25, 0);
        drain_a("ramp");
        chk("ramp_count", 32'(got_a.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("ramp_lit", (i < got_a.size()) ? got_a[i] : '0, lit[i]);

        // Negative plane with one larger value
        neg = new[25];
        for (int k = 0; k < 25; k++) neg[k] = 32'hBF800000;
        neg[6] = 32'hBF000000;
        got_a.delete();
        feed(0, neg, 5, 25, 0);
        drain_a("neg");
        chk("neg_count", 32'(got_a.size()), 32'd4);
        chk("neg_first", (got_a.size() > 0) ? got_a[0] : '0, 32'hBF000000);
        for (int i = 1; i < 4; i++) chk("neg_rest", (i < got_a.size()) ? got_a[i] : '0, 32'hBF800000);

        // Two back-to-back WIDTH=35 planes of random floats
        rnd = new[2450];
        for (int k = 0; k < 2450; k++) rnd[k] = rand_float();
        feed(1, rnd, 35, 2450, 0);
        repeat (4) @(negedge clk);
        #1;
        chk("big_pending", 32'(qb.size()), 32'd0);
        chk("big_count", 32'(nb_out), 32'd578);

        // Ramp with input bubbles
        got_a.delete();
        feed(0, ramp, 5, 25, 40);
        drain_a("bubble");
        chk("bubble_count", 32'(got_a.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("bubble_lit", (i < got_a.size()) ? got_a[i] : '0, lit[i]);

        // Reset mid-plane, just after a window trigger; valid_in during reset is ignored
        got_a.delete();
        feed(0, ramp, 5, 13, 0);
        rst_a = 1'b1;
        vin_a = 1'b1;
        pin_a = 32'h7F000000;
        qa.delete();
        @(negedge clk); #1;
        chk("rst_drop_vout", 32'(vout_a), 32'd0);
        rst_a = 1'b0;
        vin_a = 1'b0;
        feed(0, ramp, 5, 25, 0);
        drain_a("rstmid");
        chk("rstmid_count", 32'(got_a.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("rstmid_lit", (i < got_a.size()) ? got_a[i] : '0, lit[i]);

        // Signed-zero tie: +0 bottom-right, -0 elsewhere in the window
        zer = new[25];
        for (int k = 0; k < 25; k++) zer[k] = 32'hC0000000;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) zer[r*5 + c] = 32'h80000000;
        zer[12] = 32'h00000000;
        got_a.delete();
        feed(0, zer, 5, 25, 0);
        drain_a("zero");
        chk("zero_count", 32'(got_a.size()), 32'd4);
        chk("zero_first", (got_a.size() > 0) ? got_a[0] : 32'hFFFFFFFF, 32'h00000000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
